// File: rtl/mmu_xlate_arbiter.sv
// Round-robin share of one MMU lookup port between data (D) and fetch (I) requesters.
// One lookup in flight; done LOOKUP_LAT+1 cycles after ack; req is held until ack, TLB writes stall grant/lookup.
module mmu_xlate_arbiter #(
    parameter int unsigned LOOKUP_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_res,
    input  logic        i_reqD,
    input  logic [31:0] i_vAddrD,
    input  logic        i_isStoreD,
    output logic        o_ackD,
    output logic        o_doneD,
    input  logic        i_reqI,
    input  logic [31:0] i_vAddrI,
    output logic        o_ackI,
    output logic        o_doneI,
    output logic [31:0] o_pAddrOut,
    output logic [1:0]  o_fault,
    output logic        o_busy,
    output logic [31:0] o_mmuVAddr,
    input  logic [31:0] i_mmuPAddr,
    input  logic        i_tlbMiss,
    input  logic        i_tlbInvalid,
    input  logic        i_tlbModified,
    input  logic        i_writeTlb
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(LOOKUP_LAT);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_lastI;
    logic        r_sideI;
    logic        r_isStore;
    logic [31:0] r_vaddr;
    logic [31:0] r_paddr;
    logic [1:0]  r_fault;

    state_t      w_next;
    logic        w_grantD;
    logic        w_grantI;
    logic [1:0]  w_fault;

    always_comb begin
        w_next   = r_state;
        w_grantD = 1'b0;
        w_grantI = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A TLB write in progress blocks new grants so no lookup sees a partial entry.
                if (!i_writeTlb && !i_res) begin
                    if (i_reqD && (!i_reqI || r_lastI)) begin
                        w_grantD = 1'b1;
                    end else if (i_reqI) begin
                        w_grantI = 1'b1;
                    end
                end
                if (w_grantD || w_grantI) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_writeTlb && (r_cnt == 4'd1)) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_fault = 2'b00;
        if (i_tlbMiss) begin
            w_fault = 2'b01;
        end else if (i_tlbInvalid) begin
            w_fault = 2'b10;
        end else if (i_tlbModified && r_isStore) begin
            w_fault = 2'b11;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_lastI   <= 1'b1;
            r_sideI   <= 1'b0;
            r_isStore <= 1'b0;
            r_vaddr   <= 32'd0;
            r_paddr   <= 32'd0;
            r_fault   <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_grantD) begin
                r_vaddr   <= i_vAddrD;
                r_sideI   <= 1'b0;
                r_isStore <= i_isStoreD;
                r_lastI   <= 1'b0;
                r_cnt     <= LAT;
            end else if (w_grantI) begin
                r_vaddr   <= i_vAddrI;
                r_sideI   <= 1'b1;
                r_isStore <= 1'b0;
                r_lastI   <= 1'b1;
                r_cnt     <= LAT;
            end
            if (r_state == S_WAIT) begin
                // A TLB write mid-lookup makes the pending result stale: restart the count.
                if (i_writeTlb) begin
                    r_cnt <= LAT;
                end else if (r_cnt == 4'd1) begin
                    r_paddr <= i_mmuPAddr;
                    r_fault <= w_fault;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    assign o_ackD     = w_grantD;
    assign o_ackI     = w_grantI;
    assign o_doneD    = (r_state == S_RESP) && !r_sideI;
    assign o_doneI    = (r_state == S_RESP) && r_sideI;
    assign o_busy     = (r_state != S_IDLE);
    assign o_mmuVAddr = (r_state == S_WAIT) ? r_vaddr : 32'd0;
    assign o_pAddrOut = r_paddr;
    assign o_fault    = r_fault;

endmodule

// File: tb/tb_mmu_xlate_arbiter.sv
// Bench for mmu_xlate_arbiter: instance A (LOOKUP_LAT=1) and B (LOOKUP_LAT=3) share stimulus;
// the idle instance is held in reset while the other is exercised.
module tb_mmu_xlate_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res_a, res_b, sel, mon_en;
    logic        reqD, isStoreD, reqI, tlbMiss, tlbInvalid, tlbModified, writeTlb;
    logic [31:0] vAddrD, vAddrI, key;

    logic        ackD_a, doneD_a, ackI_a, doneI_a, busy_a;
    logic        ackD_b, doneD_b, ackI_b, doneI_b, busy_b;
    logic [31:0] pAddrOut_a, mmuVAddr_a, mmuPAddr_a;
    logic [31:0] pAddrOut_b, mmuVAddr_b, mmuPAddr_b;
    logic [1:0]  fault_a, fault_b;

    // MMU model: keeps the page offset and XORs in a key that a TLB write may change.
    assign mmuPAddr_a = {16'h0, mmuVAddr_a[15:0]} ^ key;
    assign mmuPAddr_b = {16'h0, mmuVAddr_b[15:0]} ^ key;

    mmu_xlate_arbiter #(.LOOKUP_LAT(1)) u_dut_a (
        .i_clk(clk), .i_res(res_a),
        .i_reqD(reqD), .i_vAddrD(vAddrD), .i_isStoreD(isStoreD), .o_ackD(ackD_a), .o_doneD(doneD_a),
        .i_reqI(reqI), .i_vAddrI(vAddrI), .o_ackI(ackI_a), .o_doneI(doneI_a),
        .o_pAddrOut(pAddrOut_a), .o_fault(fault_a), .o_busy(busy_a), .o_mmuVAddr(mmuVAddr_a),
        .i_mmuPAddr(mmuPAddr_a), .i_tlbMiss(tlbMiss), .i_tlbInvalid(tlbInvalid),
        .i_tlbModified(tlbModified), .i_writeTlb(writeTlb)
    );

    mmu_xlate_arbiter #(.LOOKUP_LAT(3)) u_dut_b (
        .i_clk(clk), .i_res(res_b),
        .i_reqD(reqD), .i_vAddrD(vAddrD), .i_isStoreD(isStoreD), .o_ackD(ackD_b), .o_doneD(doneD_b),
        .i_reqI(reqI), .i_vAddrI(vAddrI), .o_ackI(ackI_b), .o_doneI(doneI_b),
        .o_pAddrOut(pAddrOut_b), .o_fault(fault_b), .o_busy(busy_b), .o_mmuVAddr(mmuVAddr_b),
        .i_mmuPAddr(mmuPAddr_b), .i_tlbMiss(tlbMiss), .i_tlbInvalid(tlbInvalid),
        .i_tlbModified(tlbModified), .i_writeTlb(writeTlb)
    );

    logic        ackD_s, ackI_s, doneD_s, doneI_s, busy_s;
    logic [31:0] pAddr_s;
    logic [1:0]  fault_s;
    assign ackD_s  = sel ? ackD_b     : ackD_a;
    assign ackI_s  = sel ? ackI_b     : ackI_a;
    assign doneD_s = sel ? doneD_b    : doneD_a;
    assign doneI_s = sel ? doneI_b    : doneI_a;
    assign busy_s  = sel ? busy_b     : busy_a;
    assign pAddr_s = sel ? pAddrOut_b : pAddrOut_a;
    assign fault_s = sel ? fault_b    : fault_a;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit          sideI;
        logic [31:0] pa;
        logic [1:0]  flt;
        int          cyc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting at cycle %0d", name, cyc);
    endtask

    // Monitor: pops one expectation per done and checks result, side and arrival cycle.
    exp_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ack_with_done", 32'((ackD_s | ackI_s) & (doneD_s | doneI_s)), 32'd0);
            chk("ack_both", 32'(ackD_s & ackI_s), 32'd0);
            if (doneD_s || doneI_s) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got doneD=%0b doneI=%0b with nothing outstanding at cycle %0d",
                             doneD_s, doneI_s, cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_side", 32'({doneD_s, doneI_s}), e.sideI ? 32'd1 : 32'd2);
                    chk("pAddrOut", pAddr_s, e.pa);
                    chk("fault", 32'(fault_s), 32'(e.flt));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Raise a request, check its ack arrives exp_dly cycles later, then queue the expected result.
    task automatic issue(input bit sideI, input logic [31:0] va, input bit st, input int exp_dly,
                         input logic [31:0] exp_pa, input logic [1:0] exp_flt, input int lat, input int extra);
        int start;
        int n;
        start = cyc;
        if (sideI) begin
            reqI = 1'b1; vAddrI = va;
        end else begin
            reqD = 1'b1; vAddrD = va; isStoreD = st;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sideI ? ackI_s : ackD_s) && n < 60);
        if (!(sideI ? ackI_s : ackD_s)) begin
            timeout("ack_wait");
        end else begin
            chk("ack_cycle", 32'(cyc - start), 32'(exp_dly));
            q.push_back('{sideI, exp_pa, exp_flt, cyc + lat + 1 + extra});
        end
        @(posedge clk); #1;
        if (sideI) reqI = 1'b0;
        else begin reqD = 1'b0; isStoreD = 1'b0; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            timeout("drain");
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    bit   exp_side[4];
    int   start, n, t;

    initial begin
        res_a = 1'b1; res_b = 1'b1; sel = 1'b0; mon_en = 1'b0;
        reqD = 1'b0; isStoreD = 1'b0; reqI = 1'b0; vAddrD = 32'd0; vAddrI = 32'd0;
        tlbMiss = 1'b0; tlbInvalid = 1'b0; tlbModified = 1'b0; writeTlb = 1'b0; key = 32'd0;
        exp_side = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Both requests already held while reset is applied.
        reqD = 1'b1; vAddrD = 32'h1000_00A0;
        reqI = 1'b1; vAddrI = 32'h2000_00B0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ackD", 32'(ackD_a), 32'd0);
        chk("rst_ackI", 32'(ackI_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'({doneD_a, doneI_a}), 32'd0);
        chk("rst_pAddr", pAddrOut_a, 32'd0);
        chk("rst_fault", 32'(fault_a), 32'd0);
        chk("rst_mmuVAddr", mmuVAddr_a, 32'd0);
        chk("rst_b_busy_mmu", 32'(busy_b) | mmuVAddr_b, 32'd0);

        // Round-robin with both sides held: D,I,D,I every LOOKUP_LAT+2 cycles.
        @(posedge clk); #1;
        res_a = 1'b0; mon_en = 1'b1;
        start = cyc;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(ackD_s || ackI_s) && n < 40);
            if (!(ackD_s || ackI_s)) begin
                timeout("rr_ack");
            end else begin
                chk("rr_side", 32'(ackI_s), 32'(exp_side[k]));
                chk("rr_cycle", 32'(cyc - start), 32'(3 * k));
                q.push_back('{exp_side[k], exp_side[k] ? 32'h0000_00B0 : 32'h0000_00A0, 2'b00, cyc + 2});
            end
        end
        @(posedge clk); #1;
        reqD = 1'b0; reqI = 1'b0;
        drain();

        // Basic LAT=1 translation.
        issue(1'b0, 32'h0040_1000, 1'b0, 0, 32'h0000_1000, 2'b00, 1, 0);
        drain();

        // Fault encoding and priority.
        tlbModified = 1'b1;
        issue(1'b0, 32'h0040_2468, 1'b1, 0, 32'h0000_2468, 2'b11, 1, 0); drain();
        issue(1'b0, 32'h0040_2468, 1'b0, 0, 32'h0000_2468, 2'b00, 1, 0); drain();
        tlbMiss = 1'b1;
        issue(1'b0, 32'h0040_2468, 1'b1, 0, 32'h0000_2468, 2'b01, 1, 0); drain();
        tlbMiss = 1'b0; tlbInvalid = 1'b1;
        issue(1'b0, 32'h0050_1357, 1'b1, 0, 32'h0000_1357, 2'b10, 1, 0); drain();
        tlbInvalid = 1'b0;
        issue(1'b1, 32'h0060_0ACE, 1'b0, 0, 32'h0000_0ACE, 2'b00, 1, 0); drain();
        tlbModified = 1'b0;

        // TLB write held 3 cycles in IDLE blocks the grant.
        writeTlb = 1'b1;
        fork
            issue(1'b1, 32'h0000_5554, 1'b0, 3, 32'h0000_5554, 2'b00, 1, 0);
            begin
                repeat (3) @(posedge clk);
                #1 writeTlb = 1'b0;
            end
        join
        drain();

        // Switch to the LOOKUP_LAT=3 instance.
        res_a = 1'b1; sel = 1'b1; res_b = 1'b0; key = 32'h1111_0000;
        @(posedge clk); #1;

        // Two-cycle TLB write during WAIT: restarts the count, result reflects the new mapping.
        fork
            issue(1'b1, 32'h0080_2340, 1'b0, 0, 32'h2222_2340, 2'b00, 3, 2);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!ackI_s && n < 40);
                @(posedge clk); #1;
                writeTlb = 1'b1; key = 32'h2222_0000;
                repeat (2) @(posedge clk);
                #1 writeTlb = 1'b0;
            end
        join
        drain();

        issue(1'b0, 32'h0000_7000, 1'b0, 0, 32'h2222_7000, 2'b00, 3, 0);
        drain();

        // Reset during WAIT drops the lookup; the still-held request is granted again.
        reqD = 1'b1; vAddrD = 32'h0000_0ABC;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ackD_s && n < 40);
        if (!ackD_s) timeout("rst_mid_ack");
        t = cyc;
        @(posedge clk); #1;
        res_b = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy_before", 32'(busy_s), 32'd1);
        @(posedge clk); #1;
        res_b = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy_s), 32'd0);
        chk("rst_mid_done", 32'({doneD_s, doneI_s}), 32'd0);
        chk("rst_mid_regrant", 32'(ackD_s), 32'd1);
        chk("rst_mid_regrant_cycle", 32'(cyc - t), 32'd2);
        if (ackD_s) q.push_back('{1'b0, 32'h2222_0ABC, 2'b00, cyc + 4});
        @(posedge clk); #1;
        reqD = 1'b0;
        drain();

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
